// File: rtl/mem_read_arbiter.sv
// Two-requester AXI4 read arbiter: ICache refill bursts and LSU single-beat loads
// share one read master; the grant is held from AR handshake through the last R beat.
module mem_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [2:0]        lsu_arsize,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [7:0]        mem_arlen,
    output logic [2:0]        mem_arsize,
    output logic [1:0]        mem_arburst,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rlast,
    input  logic              mem_rvalid,
    output logic              mem_rready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AR_IFU = 3'd1,
        ST_AR_LSU = 3'd2,
        ST_R_IFU  = 3'd3,
        ST_R_LSU  = 3'd4
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   last_grant_r;
    logic   next_grant_s;

    // Read data is broadcast; only the per-requester rvalid says who owns a beat.
    assign r_data      = mem_rdata;
    assign r_resp      = mem_rresp;
    assign r_last      = mem_rlast;
    assign mem_arburst = 2'b01;

    // State and round-robin pointer; last_grant resets to LSU so IFU wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= next_state_s;
            last_grant_r <= next_grant_s;
        end
    end

    // Next-state selection and channel steering for the granted requester.
    always_comb begin
        next_state_s = state_r;
        next_grant_s = last_grant_r;
        mem_araddr   = '0;
        mem_arlen    = 8'd0;
        mem_arsize   = 3'b000;
        mem_arvalid  = 1'b0;
        ifu_arready  = 1'b0;
        lsu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        lsu_rvalid   = 1'b0;
        mem_rready   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ifu_arvalid && (!lsu_arvalid || last_grant_r)) begin
                    next_state_s = ST_AR_IFU;
                    next_grant_s = 1'b0;
                end else if (lsu_arvalid) begin
                    next_state_s = ST_AR_LSU;
                    next_grant_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_AR_IFU: begin
                mem_araddr  = ifu_araddr;
                mem_arlen   = ifu_arlen;
                mem_arsize  = 3'b010;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
                if (ifu_arvalid && mem_arready) begin
                    next_state_s = ST_R_IFU;
                end else begin
                    next_state_s = ST_AR_IFU;
                end
            end
            ST_AR_LSU: begin
                mem_araddr  = lsu_araddr;
                mem_arlen   = 8'd0;
                mem_arsize  = lsu_arsize;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
                if (lsu_arvalid && mem_arready) begin
                    next_state_s = ST_R_LSU;
                end else begin
                    next_state_s = ST_AR_LSU;
                end
            end
            ST_R_IFU: begin
                ifu_rvalid = mem_rvalid;
                mem_rready = ifu_rready;
                if (mem_rvalid && ifu_rready && mem_rlast) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_R_IFU;
                end
            end
            // The LSU beat always carries rlast, so no beat counting is needed.
            ST_R_LSU: begin
                lsu_rvalid = mem_rvalid;
                mem_rready = lsu_rready;
                if (mem_rvalid && lsu_rready && mem_rlast) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_R_LSU;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level arbitration model.
module tb_mem_read_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] ifu_araddr;
    logic [7:0]  ifu_arlen;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;
    logic        mem_rvalid;
    logic        mem_rready;

    int total = 0;
    int bad   = 0;

    mem_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arvalid(ifu_arvalid),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
        .mem_arburst(mem_arburst), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       iv;
        logic [7:0] il;
        logic       lv;
        logic       ar;
        logic       rv;
        logic       rl;
        logic       irr;
        logic       lrr;
        logic [1:0] rs;
        logic       e_iar;
        logic       e_lar;
        logic       e_mav;
        logic       e_irv;
        logic       e_lrv;
        logic       e_mrr;
        logic [31:0] e_addr;
        logic [7:0] e_len;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_in();
        ifu_arvalid = 1'b0; ifu_arlen = 8'd0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
        ifu_araddr  = 32'h8000_0000; lsu_araddr = 32'h0000_1000; lsu_arsize = 3'b010;
        mem_rdata   = 32'h1234_5678;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        zero_in();
        tick(); tick();
        reset = 1'b0;
    endtask

    // Check every handshake output at once against the expected tuple.
    task automatic chk_hs(input string nm, input logic iar, input logic lar, input logic mav,
                          input logic irv, input logic lrv, input logic mrr);
        chk({nm, ".ifu_arready"}, 32'(ifu_arready), 32'(iar));
        chk({nm, ".lsu_arready"}, 32'(lsu_arready), 32'(lar));
        chk({nm, ".mem_arvalid"}, 32'(mem_arvalid), 32'(mav));
        chk({nm, ".ifu_rvalid"},  32'(ifu_rvalid),  32'(irv));
        chk({nm, ".lsu_rvalid"},  32'(lsu_rvalid),  32'(lrv));
        chk({nm, ".mem_rready"},  32'(mem_rready),  32'(mrr));
    endtask

    // Random-phase agent and model state.
    int   m_owner;
    bit   m_addr;
    bit   m_last;
    bit   ifu_pend, lsu_pend, rv_hold;
    int   beats_left;
    logic e_mav, e_iar, e_lar, e_irv, e_lrv, e_mrr;

    initial begin
        reset = 1'b1;
        zero_in();
        #2;
        chk_hs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;

        //                iv il    lv ar rv rl irr lrr rs   | iar lar mav irv lrv mrr addr          len
        tbl.push_back('{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'd3});
        tbl.push_back('{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'd3});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 8'd0});
        tbl.push_back('{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'd1});
        tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 8'd0});
        tbl.push_back('{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
        tbl.push_back('{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'd2});
        tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});
        tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'd0});

        foreach (tbl[i]) begin
            ifu_arvalid = tbl[i].iv;  ifu_arlen  = tbl[i].il;  lsu_arvalid = tbl[i].lv;
            mem_arready = tbl[i].ar;  mem_rvalid = tbl[i].rv;  mem_rlast   = tbl[i].rl;
            ifu_rready  = tbl[i].irr; lsu_rready = tbl[i].lrr; mem_rresp   = tbl[i].rs;
            mem_rdata   = 32'hA5A5_0000 + 32'(i);
            #2;
            chk_hs($sformatf("vec%0d", i), tbl[i].e_iar, tbl[i].e_lar, tbl[i].e_mav,
                   tbl[i].e_irv, tbl[i].e_lrv, tbl[i].e_mrr);
            chk($sformatf("vec%0d.r_resp", i), 32'(r_resp), 32'(tbl[i].rs));
            chk($sformatf("vec%0d.r_data", i), r_data, 32'hA5A5_0000 + 32'(i));
            chk($sformatf("vec%0d.r_last", i), 32'(r_last), 32'(tbl[i].rl));
            chk($sformatf("vec%0d.arburst", i), 32'(mem_arburst), 32'd1);
            if (tbl[i].e_mav) begin
                chk($sformatf("vec%0d.araddr", i), mem_araddr, tbl[i].e_addr);
                chk($sformatf("vec%0d.arlen", i), 32'(mem_arlen), 32'(tbl[i].e_len));
                chk($sformatf("vec%0d.arsize", i), 32'(mem_arsize), 32'd2);
            end
            tick();
        end

        // AR stall: address held stable for 5 cycles, then both readies rise together.
        zero_in();
        ifu_araddr = 32'h8000_0040; ifu_arlen = 8'd7; ifu_arvalid = 1'b1;
        #2; chk_hs("stall_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            #2;
            chk_hs("stall_wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("stall_addr", mem_araddr, 32'h8000_0040);
            chk("stall_len", 32'(mem_arlen), 32'd7);
            tick();
        end
        mem_arready = 1'b1;
        #2; chk_hs("stall_go", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        ifu_arvalid = 1'b0; ifu_rready = 1'b1; lsu_rready = 1'b1; mem_rvalid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            mem_rlast = (b == 7);
            #2; chk_hs("ifu_beat", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
        end

        // LSU load with back-pressure on the R channel.
        zero_in();
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2004; lsu_arsize = 3'b001; mem_arready = 1'b1;
        #2; chk_hs("bp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2; chk_hs("bp_ar", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_arsize", 32'(mem_arsize), 32'd1);
        chk("bp_arlen", 32'(mem_arlen), 32'd0);
        tick();
        lsu_arvalid = 1'b0; mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        ifu_rready = 1'b1; ifu_arvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2; chk_hs("bp_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_data", r_data, 32'hDEAD_BEEF);
            tick();
        end
        lsu_rready = 1'b1;
        #2; chk_hs("bp_take", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        mem_rvalid = 1'b0; ifu_arvalid = 1'b0;
        #2; chk_hs("bp_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset after two of four IFU beats, then a lone LSU request after release.
        zero_in();
        ifu_arvalid = 1'b1; ifu_arlen = 8'd3; mem_arready = 1'b1;
        tick(); tick();
        ifu_arvalid = 1'b0; ifu_rready = 1'b1; mem_rvalid = 1'b1;
        #2; chk_hs("rst_beat1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        #2; chk_hs("rst_beat2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        reset = 1'b1; ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        #1; chk_hs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2; chk_hs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0; ifu_arvalid = 1'b0; mem_rvalid = 1'b0;
        #2; chk_hs("post_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2; chk_hs("post_lsu_ar", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_addr", mem_araddr, 32'h0000_1000);
        tick();

        // Randomized run against the arbitration model.
        do_reset();
        m_owner = -1; m_addr = 1'b0; m_last = 1'b1;
        ifu_pend = 1'b0; lsu_pend = 1'b0; rv_hold = 1'b0; beats_left = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!ifu_pend && $urandom_range(0, 3) == 0) begin
                ifu_pend = 1'b1; ifu_araddr = $urandom; ifu_arlen = 8'($urandom_range(0, 7));
            end
            if (!lsu_pend && $urandom_range(0, 3) == 0) begin
                lsu_pend = 1'b1; lsu_araddr = $urandom; lsu_arsize = 3'($urandom_range(0, 2));
            end
            ifu_arvalid = ifu_pend;
            lsu_arvalid = lsu_pend;
            mem_arready = 1'($urandom_range(0, 1));
            ifu_rready  = ($urandom_range(0, 3) != 0);
            lsu_rready  = ($urandom_range(0, 3) != 0);
            if (beats_left > 0 && !rv_hold && $urandom_range(0, 2) != 0) begin
                rv_hold   = 1'b1;
                mem_rdata = $urandom;
                mem_rresp = 2'($urandom_range(0, 3));
                mem_rlast = (beats_left == 1);
            end
            mem_rvalid = rv_hold;

            e_mav = (m_owner >= 0 && m_addr) ? (m_owner == 0 ? ifu_arvalid : lsu_arvalid) : 1'b0;
            e_iar = (m_owner == 0 && m_addr) ? mem_arready : 1'b0;
            e_lar = (m_owner == 1 && m_addr) ? mem_arready : 1'b0;
            e_irv = (m_owner == 0 && !m_addr) ? mem_rvalid : 1'b0;
            e_lrv = (m_owner == 1 && !m_addr) ? mem_rvalid : 1'b0;
            e_mrr = (m_owner >= 0 && !m_addr) ? (m_owner == 0 ? ifu_rready : lsu_rready) : 1'b0;
            #2;
            chk_hs($sformatf("rnd%0d", cyc), e_iar, e_lar, e_mav, e_irv, e_lrv, e_mrr);
            chk("rnd.r_data", r_data, mem_rdata);
            if (e_mav) begin
                chk("rnd.araddr", mem_araddr, (m_owner == 0) ? ifu_araddr : lsu_araddr);
                chk("rnd.arlen", 32'(mem_arlen), (m_owner == 0) ? 32'(ifu_arlen) : 32'd0);
                chk("rnd.arsize", 32'(mem_arsize), (m_owner == 0) ? 32'd2 : 32'(lsu_arsize));
            end

            if (m_owner < 0) begin
                if (ifu_arvalid || lsu_arvalid) begin
                    if (ifu_arvalid && lsu_arvalid) m_owner = m_last ? 0 : 1;
                    else m_owner = ifu_arvalid ? 0 : 1;
                    m_last = (m_owner == 1);
                    m_addr = 1'b1;
                end
            end else if (m_addr) begin
                if (e_mav && mem_arready) begin
                    m_addr = 1'b0;
                    if (m_owner == 0) begin
                        beats_left = int'(ifu_arlen) + 1; ifu_pend = 1'b0;
                    end else begin
                        beats_left = 1; lsu_pend = 1'b0;
                    end
                end
            end else if (mem_rvalid && e_mrr) begin
                rv_hold = 1'b0;
                beats_left--;
                if (mem_rlast) m_owner = -1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
Shares the single AXI4 read master port to memory between two requesters: the ICache refill path (IFU side, INCR bursts) and the LSU (single-beat loads). It arbitrates read-address requests and locks the grant until the last R beat of the granted transaction completes. The block sits between the ICache/LSU read ports and the system memory/crossbar read channel.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ifu_araddr  in  ADDR_W  ICache refill address
ifu_arlen  in  8  ICache burst length minus 1
ifu_arvalid  in  1  ICache AR valid
ifu_arready  out  1  ICache AR ready
ifu_rvalid  out  1  R beat valid to ICache
ifu_rready  in  1  ICache R ready
lsu_araddr  in  ADDR_W  LSU load address
lsu_arsize  in  3  LSU access size
lsu_arvalid  in  1  LSU AR valid
lsu_arready  out  1  LSU AR ready
lsu_rvalid  out  1  R beat valid to LSU
lsu_rready  in  1  LSU R ready
r_data  out  DATA_W  shared R data, broadcast to both requesters
r_resp  out  2  shared R response
r_last  out  1  shared R last
mem_araddr  out  ADDR_W  downstream AR address
mem_arlen  out  8  downstream burst length
mem_arsize  out  3  downstream size
mem_arburst  out  2  fixed 2'b01 (INCR)
mem_arvalid  out  1  downstream AR valid
mem_arready  in  1  downstream AR ready
mem_rdata  in  DATA_W  downstream R data
mem_rresp  in  2  downstream R response
mem_rlast  in  1  downstream R last
mem_rvalid  in  1  downstream R valid
mem_rready  out  1  downstream R ready

Behaviour:
- States: IDLE, AR_IFU, AR_LSU, R_IFU, R_LSU. Registered state and registered last_grant (0 = IFU, 1 = LSU).
- Asynchronous reset: state = IDLE, last_grant = 1, so the IFU wins the first tie. While in reset, all valid/ready outputs are 0.
- IDLE transitions:
  - Only ifu_arvalid -> AR_IFU.
  - Only lsu_arvalid -> AR_LSU.
  - Both -> the requester not equal to last_grant (round-robin).
  - last_grant is updated on entry to an AR_* state.
  - No output handshake occurs in IDLE, so AR latency is at least 1 cycle from request.
- AR_X:
  - mem_ar* are driven combinationally from X: IFU gives arsize = 3'b010; LSU gives arlen = 0.
  - mem_arvalid = X_arvalid; X_arready = mem_arready; the other requester's arready = 0.
  - On mem_arvalid & mem_arready -> R_X.
- R_X:
  - X_rvalid = mem_rvalid; mem_rready = X_rready; the other requester's rvalid = 0.
  - On mem_rvalid & mem_rready & mem_rlast -> IDLE.
  - For LSU the single beat always carries rlast; the block does not count beats.
- Outside the AR_* states: mem_arvalid = 0. Outside the R_* states: mem_rready = 0.
- r_data, r_resp and r_last always equal the mem_* inputs; they are qualified only by the per-requester rvalid.
- A request that drops arvalid before its handshake while in AR_X is a protocol violation. The bench must not do this, and the RTL need not handle it.
- New requests arriving during R_X wait; the arbiter never holds two outstanding transactions.
- Reset asserted mid-transaction returns the block to IDLE immediately. The downstream slave is also reset by the same reset.
- Error responses (r_resp != 0) are forwarded unchanged and do not alter sequencing.

Test Plan:
- Single IFU burst: ifu_araddr=0x80000000, arlen=3 -> mem_arvalid the cycle after the request, arsize=2, arburst=1; 4 beats reach the IFU only; state returns to IDLE after the rlast beat.
- Simultaneous requests from reset: IFU granted first; LSU granted only after the IFU rlast; the next tie is granted to IFU again (alternation over 4 ties: I,L,I,L).
- LSU load with back-pressure: lsu_rready=0 for 3 cycles -> mem_rready stays 0 and the beat holds until lsu_rready=1; lsu_rvalid never asserts while the IFU is granted.
- AR stall: mem_arready=0 for 5 cycles -> mem_araddr/arlen stay stable and the requester's arready=0; both go to 1 in the same cycle.
- Error response: mem_rresp=2'b10 on an LSU beat -> r_resp=2'b10 with lsu_rvalid=1; a subsequent IFU request is served normally.
- Reset mid-burst: assert reset after 2 of 4 IFU beats -> all valid/ready outputs are 0 immediately; after release, a fresh LSU request is granted first.
